// File: rtl/atomic_link_unit_pkg.sv
// Shared types and constants for the multi-core LL/SC reservation tracker.
package atomic_link_unit_pkg;

  localparam int ADDR_W    = 32;
  localparam int WORD_LSB  = 2;
  localparam int MAX_CORES = 8;

  typedef logic [ADDR_W-3:0] word_addr_t;

  typedef struct packed {
    logic              ll;
    logic              sc;
    logic              st;
    logic [ADDR_W-1:0] addr;
  } atomic_req_t;

endpackage

// File: rtl/atomic_link_unit_link_reg.sv
// One per-core link register: valid bit, linked word address, optional expiry counter.
// Expiry is built only when ATOMIC_LINK_TIMEOUT_EN is defined.
module atomic_link_unit_link_reg
  import atomic_link_unit_pkg::*;
#(
  parameter int WW           = ADDR_W - WORD_LSB,
  parameter int LINK_TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set,
  input  logic          clear,
  input  logic [WW-1:0] addr,
  output logic          valid,
  output logic [WW-1:0] link_addr
);

  // The address is meaningless while valid is low, so it carries no reset.
  always_ff @(posedge clk) begin
    if (set) link_addr <= addr;
  end

`ifdef ATOMIC_LINK_TIMEOUT_EN
  localparam int CW = (LINK_TIMEOUT > 2) ? $clog2(LINK_TIMEOUT) : 1;
  localparam logic [CW-1:0] AGE_MAX = CW'(LINK_TIMEOUT - 1);

  logic [CW-1:0] age;

  // A new LL outranks both invalidation and expiry on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      age   <= '0;
    end else if (set) begin
      valid <= 1'b1;
      age   <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (valid) begin
      if (age == AGE_MAX) valid <= 1'b0;
      else                age   <= age + 1'b1;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        valid <= 1'b0;
    else if (set)   valid <= 1'b1;
    else if (clear) valid <= 1'b0;
  end
`endif

endmodule

// File: rtl/atomic_link_unit.sv
// Multi-core LL/SC reservation tracker: match compare, lowest-index SC arbitration,
// store/SC invalidation fan-in. Optional reservation expiry via ATOMIC_LINK_TIMEOUT_EN.
module atomic_link_unit
  import atomic_link_unit_pkg::*;
#(
  parameter int NCORES       = 2,
  parameter int ADDR_W       = 32,
  parameter int LINK_TIMEOUT = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NCORES-1:0]              ll_valid,
  input  logic [NCORES-1:0][ADDR_W-1:0]  ll_addr,
  input  logic [NCORES-1:0]              sc_valid,
  input  logic [NCORES-1:0][ADDR_W-1:0]  sc_addr,
  input  logic [NCORES-1:0]              st_valid,
  input  logic [NCORES-1:0][ADDR_W-1:0]  st_addr,
  output logic [NCORES-1:0]              sc_done,
  output logic [NCORES-1:0]              sc_success,
  output logic [NCORES-1:0]              link_valid
);

  localparam int WW = ADDR_W - WORD_LSB;

  if (NCORES < 1 || NCORES > MAX_CORES || LINK_TIMEOUT < 2) begin : g_param_check
    $error("atomic_link_unit: NCORES must be 1..%0d and LINK_TIMEOUT >= 2", MAX_CORES);
  end

  logic [NCORES-1:0][WW-1:0]       ll_w, sc_w, st_w, link_w;
  logic [NCORES-1:0][WORD_LSB-1:0] unused_ll_lsb, unused_sc_lsb, unused_st_lsb;
  logic [NCORES-1:0]               link_v, pass, win, inv, clr;
  logic [NCORES-1:0]               done_p1, succ_p1;

  // Word granularity: byte offsets never take part in any compare.
  always_comb begin
    ll_w          = '0;
    sc_w          = '0;
    st_w          = '0;
    unused_ll_lsb = '0;
    unused_sc_lsb = '0;
    unused_st_lsb = '0;
    for (int c = 0; c < NCORES; c++) begin
      ll_w[c]          = ll_addr[c][ADDR_W-1:WORD_LSB];
      sc_w[c]          = sc_addr[c][ADDR_W-1:WORD_LSB];
      st_w[c]          = st_addr[c][ADDR_W-1:WORD_LSB];
      unused_ll_lsb[c] = ll_addr[c][WORD_LSB-1:0];
      unused_sc_lsb[c] = sc_addr[c][WORD_LSB-1:0];
      unused_st_lsb[c] = st_addr[c][WORD_LSB-1:0];
    end
  end

  always_comb begin
    pass = '0;
    for (int c = 0; c < NCORES; c++)
      pass[c] = sc_valid[c] && link_v[c] && (link_w[c] == sc_w[c]);
  end

  // Any lower-indexed passing SC to the same word takes the win.
  always_comb begin
    win = '0;
    for (int c = 0; c < NCORES; c++) begin
      win[c] = pass[c];
      for (int j = 0; j < c; j++)
        if (pass[j] && (sc_w[j] == sc_w[c])) win[c] = 1'b0;
    end
  end

  always_comb begin
    inv = '0;
    for (int c = 0; c < NCORES; c++)
      for (int k = 0; k < NCORES; k++)
        if (link_v[c] && ((st_valid[k] && (st_w[k] == link_w[c])) ||
                          (win[k] && (sc_w[k] == link_w[c]))))
          inv[c] = 1'b1;
  end

  // Every SC consumes its own reservation, pass or fail.
  assign clr = sc_valid | inv;

  for (genvar c = 0; c < NCORES; c++) begin : g_core
    atomic_link_unit_link_reg #(
      .WW           (WW),
      .LINK_TIMEOUT (LINK_TIMEOUT)
    ) u_link (
      .clk       (clk),
      .rst       (rst),
      .set       (ll_valid[c]),
      .clear     (clr[c]),
      .addr      (ll_w[c]),
      .valid     (link_v[c]),
      .link_addr (link_w[c])
    );

    a_req_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot0({ll_valid[c], sc_valid[c], st_valid[c]}));
  end

  // ---- stage p1: registered SC result ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_p1 <= '0;
      succ_p1 <= '0;
    end else begin
      done_p1 <= sc_valid;
      succ_p1 <= win;
    end
  end

  assign sc_done    = done_p1;
  assign sc_success = succ_p1;
  assign link_valid = link_v;

endmodule

// File: tb/tb_atomic_link_unit.sv
// Directed bench for atomic_link_unit (2 cores); expiry steps run when ATOMIC_LINK_TIMEOUT_EN is defined.
module tb_atomic_link_unit;

`ifdef ATOMIC_LINK_TIMEOUT_EN
  localparam int LT = 8;
`else
  localparam int LT = 1024;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        ll_valid, sc_valid, st_valid;
  logic [1:0][31:0]  ll_addr, sc_addr, st_addr;
  logic [1:0]        sc_done, sc_success, link_valid;

  int checks   = 0;
  int failures = 0;

  atomic_link_unit #(.NCORES(2), .ADDR_W(32), .LINK_TIMEOUT(LT)) dut (
    .clk        (clk),
    .rst        (rst),
    .ll_valid   (ll_valid),
    .ll_addr    (ll_addr),
    .sc_valid   (sc_valid),
    .sc_addr    (sc_addr),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .sc_done    (sc_done),
    .sc_success (sc_success),
    .link_valid (link_valid)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    ll_valid = '0; sc_valid = '0; st_valid = '0;
    ll_addr  = '0; sc_addr  = '0; st_addr  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  initial begin
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_link_valid", 32'(link_valid), 32'h0);
    chk("rst_sc_done",    32'(sc_done),    32'h0);
    chk("rst_sc_success", 32'(sc_success), 32'h0);
    rst = 1'b0;

    // LL then SC to the same word two cycles later
    ll_valid = 2'b01; ll_addr[0] = 32'h100; tick();
    chk("t1_ll_link", 32'(link_valid), 32'h1);
    tick();
    sc_valid = 2'b01; sc_addr[0] = 32'h100; tick();
    chk("t1_done",    32'(sc_done),    32'h1);
    chk("t1_success", 32'(sc_success), 32'h1);
    chk("t1_link",    32'(link_valid), 32'h0);
    tick();
    chk("t1_done_pulse", 32'(sc_done), 32'h0);

    // store from another core to the same word (different byte) kills the link
    ll_valid = 2'b01; ll_addr[0] = 32'h100; tick();
    st_valid = 2'b10; st_addr[1] = 32'h102; tick();
    chk("t2_st_inval", 32'(link_valid), 32'h0);
    sc_valid = 2'b01; sc_addr[0] = 32'h100; tick();
    chk("t2_done",    32'(sc_done),    32'h1);
    chk("t2_success", 32'(sc_success), 32'h0);

    // store to a neighbouring word leaves the link alone
    ll_valid = 2'b01; ll_addr[0] = 32'h100; tick();
    st_valid = 2'b10; st_addr[1] = 32'h104; tick();
    chk("t2_st_other_word", 32'(link_valid), 32'h1);
    sc_valid = 2'b01; sc_addr[0] = 32'h100; tick();
    chk("t2_sc_after_other", 32'(sc_success), 32'h1);

    // two SCs to the same word: lowest index wins
    ll_valid = 2'b11; ll_addr[0] = 32'h200; ll_addr[1] = 32'h200; tick();
    chk("t3_both_linked", 32'(link_valid), 32'h3);
    sc_valid = 2'b11; sc_addr[0] = 32'h200; sc_addr[1] = 32'h200; tick();
    chk("t3_done",    32'(sc_done),    32'h3);
    chk("t3_success", 32'(sc_success), 32'h1);
    chk("t3_link",    32'(link_valid), 32'h0);

    // LL beats a same-cycle store to the same word
    ll_valid = 2'b10; ll_addr[1] = 32'h300; st_valid = 2'b01; st_addr[0] = 32'h300; tick();
    chk("t4_ll_wins", 32'(link_valid), 32'h2);

    // a winning SC on core 0 invalidates core 1's link to that word
    ll_valid = 2'b01; ll_addr[0] = 32'h300; tick();
    chk("t4_both_linked", 32'(link_valid), 32'h3);
    sc_valid = 2'b01; sc_addr[0] = 32'h300; tick();
    chk("t4_sc_win",       32'(sc_success), 32'h1);
    chk("t4_sc_inval_peer", 32'(link_valid), 32'h0);

    // SC with no reservation
    sc_valid = 2'b10; sc_addr[1] = 32'h300; tick();
    chk("nolink_done",    32'(sc_done),    32'h2);
    chk("nolink_success", 32'(sc_success), 32'h0);

    // a re-LL replaces the earlier linked address
    ll_valid = 2'b01; ll_addr[0] = 32'h600; tick();
    ll_valid = 2'b01; ll_addr[0] = 32'h700; tick();
    sc_valid = 2'b01; sc_addr[0] = 32'h600; tick();
    chk("relink_old_addr", 32'(sc_success), 32'h0);

    // reset lands between SC issue and its result edge
    ll_valid = 2'b01; ll_addr[0] = 32'h400; tick();
    sc_valid = 2'b01; sc_addr[0] = 32'h400;
    #2 rst = 1'b1;
    #1;
    chk("t5_async_link", 32'(link_valid), 32'h0);
    chk("t5_async_done", 32'(sc_done),    32'h0);
    tick();
    rst = 1'b0;
    chk("t5_done_after_rst", 32'(sc_done),    32'h0);
    chk("t5_link_after_rst", 32'(link_valid), 32'h0);

`ifdef ATOMIC_LINK_TIMEOUT_EN
    // reservation expires after LINK_TIMEOUT cycles of holding
    ll_valid = 2'b01; ll_addr[0] = 32'h800; tick();
    for (int i = 0; i < 8; i++) tick();
    chk("t6_expired_link", 32'(link_valid), 32'h0);
    sc_valid = 2'b01; sc_addr[0] = 32'h800; tick();
    chk("t6_expired_sc", 32'(sc_success), 32'h0);

    ll_valid = 2'b01; ll_addr[0] = 32'h800; tick();
    for (int i = 0; i < 4; i++) tick();
    sc_valid = 2'b01; sc_addr[0] = 32'h800; tick();
    chk("t6_early_sc", 32'(sc_success), 32'h1);

    // last cycle before expiry still holds the link
    ll_valid = 2'b01; ll_addr[0] = 32'h800; tick();
    for (int i = 0; i < 7; i++) tick();
    chk("t6_edge_link", 32'(link_valid), 32'h1);
    sc_valid = 2'b01; sc_addr[0] = 32'h800; tick();
    chk("t6_edge_sc", 32'(sc_success), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
